mem_stream_writer: RTL and testbench
====================================

// Module: mem_stream_writer
// PURPOSE
//  Writer side of the byte-memory path: accepts a stream of 8-bit bytes over a
//  valid/ready handshake and stores them at auto-incrementing addresses of a 16x8 RAM.
//  Counterpart of the counter-addressed ROM read path. Bytes loaded here are read back
//  through a combinational read port, by downstream logic or by the bench.
// PARAMETERS
//  DATA_W  8   byte width of stream and memory word
//  ADDR_W  4   address width
//  DEPTH   16  words in memory (= 2**ADDR_W)
// PORTS
//  clock       in   1         single clock, rising edge
//  clearb      in   1         reset, asynchronous, active-low
//  start       in   1         1-cycle request to begin a burst (sampled in IDLE only)
//  start_addr  in   ADDR_W    first write address of burst
//  len         in   ADDR_W+1  bytes in burst, 0..DEPTH
//  in_valid    in   1         producer has byte on in_data
//  in_data     in   DATA_W    byte to write
//  in_ready    out  1         writer accepts byte this cycle
//  busy        out  1         burst in progress (state WRITE)
//  done        out  1         1-cycle pulse: burst complete
//  wr_addr     out  ADDR_W    address the next accepted byte goes to
//  rd_addr     in   ADDR_W    read address
//  rd_data     out  DATA_W    mem[rd_addr], combinational
// BEHAVIOUR
//  - clearb low (any time, async): state=IDLE, in_ready=0, busy=0, done=0, wr_addr=0,
//    remaining count=0. Memory contents are NOT cleared: unwritten words read X.
//  - FSM: IDLE -> WRITE -> DONE -> IDLE.
//  - IDLE: start=1 and len!=0 -> WRITE next edge; wr_addr<=start_addr;
//    count<=min(len,DEPTH). start=1 with len==0 -> DONE directly, no writes.
//  - WRITE: in_ready=busy=1 (decoded from state, no extra cycle of latency).
//    Beat = in_valid&in_ready at rising edge: mem[wr_addr]<=in_data,
//    wr_addr<=wr_addr+1 mod DEPTH (wraps 15->0), count<=count-1.
//    Beat with count==1 -> DONE. No beat -> hold all state. in_data is ignored while
//    in_valid=0.
//  - DONE: done=1, in_ready=0 for exactly one cycle; then IDLE.
//  - start outside IDLE is ignored: no restart, no queueing.
//  - len>DEPTH saturates to DEPTH. Wrapped addresses overwrite earlier words.
//  - Read port: write takes effect at the edge. rd_data of the same address shows the
//    old value until then (write-then-read, no bypass).
//  - Reset mid-burst: bytes already written stay in memory, partial burst is dropped,
//    no done pulse is generated.
// STRUCTURE
//  - Shared package: DATA_W/ADDR_W/DEPTH constants; state enum IDLE=2'd0, WRITE=2'd1,
//    DONE=2'd2.
//  - Sub-module mem_16x8: 1 sync write port (we, waddr, wdata), 1 async read port,
//    no reset.
//  - Top holds the FSM, the address counter and the remaining-count counter.
// TESTING
//  1 Reset: clearb->0 between clock edges during WRITE -> in_ready/busy/done/wr_addr = 0
//    immediately, before the next edge.
//  2 start_addr=0 len=4, bytes CC,AA,CC,AA back-to-back -> 4 beats; done high in the
//    cycle after the 4th beat; rd mem[0..3]=CC,AA,CC,AA.
//  3 Backpressure: len=3, in_valid pattern 1,0,0,1,0,1 with bytes 11,22,33 -> only
//    valid beats written; mem[a..a+2]=11,22,33; busy=1 for exactly 6 cycles.
//  4 Wrap: start_addr=14 len=4, bytes 01..04 -> mem[14]=01, mem[15]=02, mem[0]=03,
//    mem[1]=04; wr_addr=2 after the burst.
//  5 Edge lengths: len=0 -> done 1 cycle after start, no writes. len=20 -> exactly 16
//    beats accepted.
//  6 start=1 pulsed during WRITE -> ignored. clearb low after 2 of 4 beats -> IDLE; the
//    2 written words keep their values; no done pulse.

Source files
------------

// File: rtl/mem_stream_writer_pkg.sv
// Shared constants, FSM state encoding and length helper for the byte-stream memory writer.
package mem_stream_writer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    // Burst length counter is one bit wider than the address so it can hold DEPTH itself.
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] len);
        return (len > DEPTH_CNT) ? DEPTH_CNT : len;
    endfunction

endpackage

// File: rtl/mem_stream_writer_if.sv
// Handshake, control and read-port bundle of the byte-stream memory writer.
interface mem_stream_writer_if;
    import mem_stream_writer_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output start, start_addr, len, in_valid, in_data, rd_addr,
        input  in_ready, busy, done, wr_addr, rd_data
    );

    modport slave (
        input  start, start_addr, len, in_valid, in_data, rd_addr,
        output in_ready, busy, done, wr_addr, rd_data
    );

endinterface

// File: rtl/mem_stream_writer_mem.sv
// 16x8 storage: one synchronous write port, one combinational read port, no reset.
module mem_16x8
    import mem_stream_writer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // No write-to-read bypass: a same-address read sees the old word until the edge.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_stream_writer.sv
// Burst writer: accepts a valid/ready byte stream and stores it at auto-incrementing addresses.
module mem_stream_writer
    import mem_stream_writer_pkg::*;
(
    input  logic               clock,
    input  logic               clearb,
    mem_stream_writer_if.slave bus
);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_count;

    logic w_in_ready;
    logic w_busy;
    logic w_done;
    logic w_beat;
    logic w_load;
    logic w_last;

    assign w_beat = bus.in_valid & w_in_ready;
    assign w_load = (r_state == StIdle) & bus.start & (bus.len != '0);
    assign w_last = (r_count == (ADDR_W + 1)'(1));

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                // A zero-length request still reports completion, without writing.
                if (bus.start) begin
                    w_state_next = (bus.len != '0) ? StWrite : StDone;
                end
            end
            StWrite: begin
                if (w_beat && w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            StWrite: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            StDone:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            r_wr_addr <= '0;
            r_count   <= '0;
        end else if (w_load) begin
            r_wr_addr <= bus.start_addr;
            r_count   <= sat_len(bus.len);
        end else if (w_beat) begin
            // Address wraps naturally at DEPTH; later beats overwrite earlier words.
            r_wr_addr <= r_wr_addr + 1'b1;
            r_count   <= r_count - 1'b1;
        end
    end

    mem_16x8 u_mem (
        .i_clk   (clock),
        .i_we    (w_beat),
        .i_waddr (r_wr_addr),
        .i_wdata (bus.in_data),
        .i_raddr (bus.rd_addr),
        .o_rdata (bus.rd_data)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.wr_addr  = r_wr_addr;

    a_write_has_count: assert property (@(posedge clock) disable iff (!clearb)
        (r_state == StWrite) |-> (r_count != '0));

    a_done_one_cycle: assert property (@(posedge clock) disable iff (!clearb)
        w_done |=> !w_done);

endmodule

// File: tb/tb_mem_stream_writer.sv
// Scoreboard bench for mem_stream_writer: expected (addr, byte) pairs queued per beat, read back.
module tb_mem_stream_writer;

    logic clock = 1'b0;
    logic clearb = 1'b0;

    always #5 clock = ~clock;

    mem_stream_writer_if bus ();

    mem_stream_writer u_dut (
        .clock  (clock),
        .clearb (clearb),
        .bus    (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] sb[$];
    logic [7:0]  tx_data[$];
    bit          vld_pat[$];
    logic [7:0]  exp_mem[16];

    int busy_cyc, beats, done_cyc, last_beat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drain_sb();
        logic [11:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.rd_addr = e[11:8];
            #1;
            check_eq($sformatf("mem[%0d]", e[11:8]), 32'(bus.rd_data), 32'(e[7:0]));
        end
    endtask

    task automatic run_burst(input logic [3:0] addr, input logic [4:0] n,
                             output int o_busy, output int o_beats,
                             output int o_done_cyc, output int o_last_beat);
        logic [3:0] a;
        bit         v;
        bit         got_done;
        a = addr;
        o_busy = 0;
        o_beats = 0;
        o_done_cyc = -1;
        o_last_beat = -1;
        got_done = 1'b0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.start_addr = addr;
        bus.len = n;
        @(negedge clock);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 64 && !got_done; cyc++) begin
            v = (vld_pat.size() > 0) ? vld_pat.pop_front() : 1'b1;
            bus.in_valid = v && (tx_data.size() > 0);
            bus.in_data = bus.in_valid ? tx_data[0] : 8'($urandom);
            #1;
            if (bus.done) begin
                got_done = 1'b1;
                o_done_cyc = cyc;
            end
            if (bus.busy) o_busy++;
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back({a, bus.in_data});
                exp_mem[a] = bus.in_data;
                a++;
                o_beats++;
                o_last_beat = cyc;
                void'(tx_data.pop_front());
            end
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        #1;
        check_eq("done_seen", 32'(got_done), 32'd1);
        check_eq("done_one_cycle", 32'(bus.done), 32'd0);
        check_eq("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.rd_addr = '0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        clearb = 1'b1;

        // Back-to-back burst of four
        tx_data = '{8'hCC, 8'hAA, 8'hCC, 8'hAA};
        run_burst(4'd0, 5'd4, busy_cyc, beats, done_cyc, last_beat);
        check_eq("t2_beats", 32'(beats), 32'd4);
        check_eq("t2_busy", 32'(busy_cyc), 32'd4);
        check_eq("t2_done_lat", 32'(done_cyc), 32'(last_beat + 1));
        check_eq("t2_wr_addr", 32'(bus.wr_addr), 32'd4);
        drain_sb();

        // Backpressure
        tx_data = '{8'h11, 8'h22, 8'h33};
        vld_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_burst(4'd5, 5'd3, busy_cyc, beats, done_cyc, last_beat);
        check_eq("t3_beats", 32'(beats), 32'd3);
        check_eq("t3_busy", 32'(busy_cyc), 32'd6);
        check_eq("t3_done_lat", 32'(done_cyc), 32'(last_beat + 1));
        drain_sb();

        // Address wrap
        tx_data = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_burst(4'd14, 5'd4, busy_cyc, beats, done_cyc, last_beat);
        check_eq("t4_beats", 32'(beats), 32'd4);
        check_eq("t4_wr_addr", 32'(bus.wr_addr), 32'd2);
        drain_sb();

        // Zero length: immediate done, no writes
        tx_data = '{8'hEE};
        run_burst(4'd7, 5'd0, busy_cyc, beats, done_cyc, last_beat);
        check_eq("t5_len0_beats", 32'(beats), 32'd0);
        check_eq("t5_len0_done", 32'(done_cyc), 32'd0);
        check_eq("t5_len0_busy", 32'(busy_cyc), 32'd0);
        bus.rd_addr = 4'd7;
        #1;
        check_eq("t5_len0_mem7", 32'(bus.rd_data), 32'h33);
        tx_data.delete();

        // Oversized length saturates to DEPTH
        for (int i = 0; i < 20; i++) tx_data.push_back(8'(8'h40 + i));
        run_burst(4'd3, 5'd20, busy_cyc, beats, done_cyc, last_beat);
        check_eq("t5_len20_beats", 32'(beats), 32'd16);
        check_eq("t5_len20_busy", 32'(busy_cyc), 32'd16);
        check_eq("t5_len20_wr_addr", 32'(bus.wr_addr), 32'd3);
        tx_data.delete();
        drain_sb();

        // Ignored start mid-burst, write-then-read ordering, reset mid-burst
        @(negedge clock);
        bus.start = 1'b1;
        bus.start_addr = 4'd8;
        bus.len = 5'd4;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_data = 8'hE1;
        bus.start_addr = 4'd0;
        bus.len = 5'd2;
        bus.rd_addr = 4'd8;
        #1;
        check_eq("t6_old_before_edge", 32'(bus.rd_data), 32'(exp_mem[8]));
        sb.push_back({4'd8, 8'hE1});
        exp_mem[8] = 8'hE1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.in_data = 8'hE2;
        #1;
        check_eq("t6_new_after_edge", 32'(bus.rd_data), 32'hE1);
        check_eq("t6_start_ignored", 32'(bus.wr_addr), 32'd9);
        sb.push_back({4'd9, 8'hE2});
        exp_mem[9] = 8'hE2;
        @(negedge clock);
        bus.in_valid = 1'b0;
        #1;
        check_eq("t6_wr_addr_2beats", 32'(bus.wr_addr), 32'd10);
        check_eq("t6_busy_mid", 32'(bus.busy), 32'd1);
        #1;
        clearb = 1'b0;
        #1;
        check_eq("t1_async_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("t1_async_busy", 32'(bus.busy), 32'd0);
        check_eq("t1_async_done", 32'(bus.done), 32'd0);
        check_eq("t1_async_wr_addr", 32'(bus.wr_addr), 32'd0);
        @(negedge clock);
        clearb = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check_eq("t6_no_done_after_rst", 32'(saw_done), 32'd0);
        drain_sb();
        bus.rd_addr = 4'd10;
        #1;
        check_eq("t6_mem10_untouched", 32'(bus.rd_data), 32'(exp_mem[10]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
